// File: rtl/i2c_ld_target.sv
// I2C register target: seven 8-bit registers behind a 3-bit auto-incrementing pointer.
// Define I2C_LD_TARGET_GLITCH_FILTER_EN to add a 3-sample glitch filter on SCL/SDA.
module i2c_ld_target #(
  parameter logic [6:0] DEV_ADDR = 7'h7E
) (
  input  logic        CLK40,
  input  logic        RST_B,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  output logic [55:0] REGS,
  output logic        WR_STB,
  output logic [2:0]  WR_IDX,
  output logic        BUSY
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  localparam logic [55:0] REGS_DEFAULT = 56'h04FFFF88008087;

  logic [1:0]  r_scl_sync, r_sda_sync;
  logic        r_scl_d, r_sda_d;
  logic        w_scl, w_sda;
  logic        w_rise, w_fall, w_start, w_stop;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bitcnt, w_bitcnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic [2:0]  r_ptr, w_ptr_nxt;
  logic        r_sda_oe, w_oe_nxt;
  logic        r_rw, w_rw_nxt;
  logic        r_mack, w_mack_nxt;
  logic        w_we;
  logic [7:0]  w_byte, w_rd_byte;
  logic        r_wr_stb;
  logic [2:0]  r_wr_idx;
  logic [55:0] r_regs;

  always_ff @(posedge CLK40) begin
    if (!RST_B) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], SCL_IN};
      r_sda_sync <= {r_sda_sync[0], SDA_IN};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

`ifdef I2C_LD_TARGET_GLITCH_FILTER_EN
  // A line only changes once the synchronized value has been stable for 3 samples.
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_filt, r_sda_filt;

  always_comb begin
    w_scl = r_scl_filt;
    w_sda = r_sda_filt;
    if (r_scl_hist == {2{r_scl_sync[1]}}) w_scl = r_scl_sync[1];
    if (r_sda_hist == {2{r_sda_sync[1]}}) w_sda = r_sda_sync[1];
  end

  always_ff @(posedge CLK40) begin
    if (!RST_B) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_filt <= 1'b1;
      r_sda_filt <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_filt <= w_scl;
      r_sda_filt <= w_sda;
    end
  end
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte  = {r_shift[6:0], w_sda};

  // Pointer 7 has no backing register and reads as zero.
  always_comb begin
    w_rd_byte = 8'h00;
    for (int i = 0; i < 7; i++) begin
      if (r_ptr == 3'(i)) w_rd_byte = r_regs[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_oe_nxt     = r_sda_oe;
    w_rw_nxt     = r_rw;
    w_mack_nxt   = r_mack;
    w_we         = 1'b0;
    if (w_start) begin
      w_state_nxt  = ADDR;
      w_bitcnt_nxt = 3'd0;
      w_oe_nxt     = 1'b0;
    end else if (w_stop) begin
      w_state_nxt  = IDLE;
      w_bitcnt_nxt = 3'd0;
      w_oe_nxt     = 1'b0;
    end else begin
      case (r_state)
        IDLE: ;
        ADDR, PTR, WR_DATA: begin
          if (w_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_bitcnt_nxt = 3'd0;
              if (r_state == ADDR) begin
                w_rw_nxt    = w_byte[0];
                w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
              end else if (r_state == PTR) begin
                w_ptr_nxt   = w_byte[2:0];
                w_state_nxt = PTR_ACK;
              end else begin
                w_we        = (r_ptr != 3'd7);
                w_ptr_nxt   = r_ptr + 3'd1;
                w_state_nxt = WR_ACK;
              end
            end
          end
        end
        // Counter 0 = before the 9th SCL rise, 1 = after it.
        ADDR_ACK, PTR_ACK, WR_ACK: begin
          if (w_rise) begin
            w_bitcnt_nxt = 3'd1;
          end else if (w_fall) begin
            if (r_bitcnt == 3'd0) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_bitcnt_nxt = 3'd0;
              w_oe_nxt     = 1'b0;
              if (r_state == ADDR_ACK && r_rw) begin
                w_state_nxt = RD_DATA;
                w_shift_nxt = w_rd_byte;
                w_oe_nxt    = ~w_rd_byte[7];
              end else if (r_state == ADDR_ACK) begin
                w_state_nxt = PTR;
              end else begin
                w_state_nxt = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (w_rise) begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              w_bitcnt_nxt = 3'd0;
              w_ptr_nxt    = r_ptr + 3'd1;
              w_state_nxt  = RD_ACK;
            end
          end else if (w_fall) begin
            w_shift_nxt = {r_shift[6:0], r_shift[7]};
            w_oe_nxt    = ~r_shift[6];
          end
        end
        RD_ACK: begin
          if (w_rise) begin
            w_bitcnt_nxt = 3'd1;
            w_mack_nxt   = ~w_sda;
          end else if (w_fall) begin
            w_oe_nxt = 1'b0;
            if (r_bitcnt != 3'd0) begin
              w_bitcnt_nxt = 3'd0;
              if (r_mack) begin
                w_state_nxt = RD_DATA;
                w_shift_nxt = w_rd_byte;
                w_oe_nxt    = ~w_rd_byte[7];
              end else begin
                w_state_nxt = IDLE;
              end
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK40) begin
    if (!RST_B) begin
      r_state  <= IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_ptr    <= 3'd0;
      r_sda_oe <= 1'b0;
      r_rw     <= 1'b0;
      r_mack   <= 1'b0;
      r_wr_stb <= 1'b0;
      r_wr_idx <= 3'd0;
      r_regs   <= REGS_DEFAULT;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sda_oe <= w_oe_nxt;
      r_rw     <= w_rw_nxt;
      r_mack   <= w_mack_nxt;
      r_wr_stb <= w_we;
      if (w_we) r_wr_idx <= r_ptr;
      for (int i = 0; i < 7; i++) begin
        if (w_we && r_ptr == 3'(i)) r_regs[8*i +: 8] <= w_byte;
      end
    end
  end

  assign SDA_OE = r_sda_oe;
  assign REGS   = r_regs;
  assign WR_STB = r_wr_stb;
  assign WR_IDX = r_wr_idx;
  assign BUSY   = (r_state != IDLE) && (r_state != ADDR);

endmodule

// File: tb/tb_i2c_ld_target.sv
// Self-checking bench for i2c_ld_target: bit-banged I2C master plus a register-file model.
// The glitch scenario runs only when I2C_LD_TARGET_GLITCH_FILTER_EN is defined.
module tb_i2c_ld_target;

  localparam int Q = 6;
  localparam int H = 12;
  localparam logic [55:0] RESET_REGS = 56'h04FFFF88008087;

  logic        CLK40 = 1'b0;
  logic        RST_B = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sdaBus;
  logic        SDA_OE, WR_STB, BUSY;
  logic [55:0] REGS;
  logic [2:0]  WR_IDX;

  int checks = 0;
  int failures = 0;

  logic [7:0] mregs [7];
  int         mptr;
  int         expStb[$];
  int         gotStb[$];
  bit         busySeen;

  logic [7:0] wbuf [16];
  logic       wacks [17];
  logic [7:0] rbuf [16];
  logic       raddrAck;
  logic       rOeAfter;

  assign sdaBus = m_sda & ~SDA_OE;

  always #5 CLK40 = ~CLK40;

  i2c_ld_target dut (
    .CLK40 (CLK40),
    .RST_B (RST_B),
    .SCL_IN(m_scl),
    .SDA_IN(sdaBus),
    .SDA_OE(SDA_OE),
    .REGS  (REGS),
    .WR_STB(WR_STB),
    .WR_IDX(WR_IDX),
    .BUSY  (BUSY)
  );

  always @(negedge CLK40) begin
    if (WR_STB) gotStb.push_back(int'(WR_IDX));
    if (BUSY) busySeen = 1'b1;
  end

  function automatic void model_reset();
    mregs = '{8'h87, 8'h80, 8'h00, 8'h88, 8'hFF, 8'hFF, 8'h04};
    mptr = 0;
  endfunction

  function automatic logic [55:0] model_regs();
    logic [55:0] r;
    for (int i = 0; i < 7; i++) r[8*i +: 8] = mregs[i];
    return r;
  endfunction

  function automatic void model_write(input int n);
    mptr = int'(wbuf[0][2:0]);
    for (int i = 1; i < n; i++) begin
      if (mptr < 7) begin
        mregs[mptr] = wbuf[i];
        expStb.push_back(mptr);
      end
      mptr = (mptr + 1) % 8;
    end
  endfunction

  function automatic logic [7:0] model_read();
    logic [7:0] v;
    v = (mptr < 7) ? mregs[mptr] : 8'h00;
    mptr = (mptr + 1) % 8;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK40);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b0; tick(H);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(H);
    m_sda = 1'b1; tick(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input int glitchBit, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; tick(Q);
      m_scl = 1'b1;
      if (i == glitchBit) begin
        tick(H/2); m_scl = 1'b0; tick(1); m_scl = 1'b1; tick(H/2 - 1);
      end else begin
        tick(H);
      end
      m_scl = 1'b0; tick(Q);
    end
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(H/2);
    ack = ~sdaBus;
    tick(H/2);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(Q);
      m_scl = 1'b1; tick(H/2);
      b[i] = sdaBus;
      tick(H/2);
      m_scl = 1'b0; tick(Q);
    end
    m_sda = mack ? 1'b0 : 1'b1; tick(Q);
    m_scl = 1'b1; tick(H);
    m_scl = 1'b0; tick(Q);
    m_sda = 1'b1;
  endtask

  task automatic write_txn(input int n, input bit doStop, input int glitchByte);
    logic a;
    i2c_start();
    send_byte(8'hFC, -1, a);
    wacks[0] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], (i == glitchByte) ? 3 : -1, a);
      wacks[i+1] = a;
    end
    if (doStop) begin
      i2c_stop();
      tick(4);
    end
  endtask

  task automatic read_txn(input int n);
    logic a;
    logic [7:0] b;
    i2c_start();
    send_byte(8'hFD, -1, a);
    raddrAck = a;
    for (int k = 0; k < n; k++) begin
      recv_byte(k < n - 1, b);
      rbuf[k] = b;
    end
    tick(2);
    rOeAfter = SDA_OE;
    i2c_stop();
    tick(4);
  endtask

  task automatic test_reset();
    RST_B = 1'b0;
    model_reset();
    tick(3);
    checks++; if (SDA_OE !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe got=%b want=0", SDA_OE); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b want=0", BUSY); end
    checks++; if (WR_STB !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_stb got=%b want=0", WR_STB); end
    checks++; if (WR_IDX !== 3'd0) begin failures++; $display("[TB] FAIL reset_wr_idx got=%0d want=0", WR_IDX); end
    checks++; if (REGS !== RESET_REGS) begin failures++; $display("[TB] FAIL reset_regs got=%h want=%h", REGS, RESET_REGS); end
    RST_B = 1'b1;
    tick(4);
  endtask

  task automatic test_default_read();
    logic [7:0] exp;
    read_txn(7);
    checks++; if (raddrAck !== 1'b1) begin failures++; $display("[TB] FAIL default_read_addr_ack got=%b want=1", raddrAck); end
    for (int k = 0; k < 7; k++) begin
      exp = model_read();
      checks++; if (rbuf[k] !== exp) begin failures++; $display("[TB] FAIL default_read_byte%0d got=%h want=%h", k, rbuf[k], exp); end
    end
    checks++; if (rOeAfter !== 1'b0) begin failures++; $display("[TB] FAIL default_read_release got=%b want=0", rOeAfter); end
  endtask

  task automatic test_write_all();
    wbuf[0] = 8'h00; wbuf[1] = 8'h64; wbuf[2] = 8'h55; wbuf[3] = 8'h33;
    wbuf[4] = 8'hE7; wbuf[5] = 8'h1C; wbuf[6] = 8'h73; wbuf[7] = 8'h02;
    expStb.delete(); gotStb.delete();
    write_txn(8, 1'b1, -1);
    model_write(8);
    for (int i = 0; i < 9; i++) begin
      checks++; if (wacks[i] !== 1'b1) begin failures++; $display("[TB] FAIL write_all_ack%0d got=%b want=1", i, wacks[i]); end
    end
    checks++; if (gotStb.size() != expStb.size()) begin failures++; $display("[TB] FAIL write_all_stb_count got=%0d want=%0d", gotStb.size(), expStb.size()); end
    for (int i = 0; i < expStb.size() && i < gotStb.size(); i++) begin
      checks++; if (gotStb[i] != expStb[i]) begin failures++; $display("[TB] FAIL write_all_wr_idx%0d got=%0d want=%0d", i, gotStb[i], expStb[i]); end
    end
    checks++; if (REGS !== model_regs()) begin failures++; $display("[TB] FAIL write_all_regs got=%h want=%h", REGS, model_regs()); end
  endtask

  task automatic test_bad_addr();
    logic a;
    busySeen = 1'b0;
    gotStb.delete();
    i2c_start();
    send_byte(8'hF8, -1, a);
    send_byte(8'h01, -1, a);
    i2c_stop();
    tick(4);
    checks++; if (wacks[0] !== 1'b1 || a !== 1'b0) begin failures++; $display("[TB] FAIL bad_addr_ack got=%b want=0", a); end
    checks++; if (busySeen !== 1'b0) begin failures++; $display("[TB] FAIL bad_addr_busy got=%b want=0", busySeen); end
    checks++; if (gotStb.size() != 0) begin failures++; $display("[TB] FAIL bad_addr_stb got=%0d want=0", gotStb.size()); end
    checks++; if (REGS !== model_regs()) begin failures++; $display("[TB] FAIL bad_addr_regs got=%h want=%h", REGS, model_regs()); end
  endtask

  task automatic test_ptr_wrap();
    logic [7:0] exp;
    wbuf[0] = 8'h05;
    write_txn(1, 1'b0, -1);
    model_write(1);
    read_txn(4);
    checks++; if (raddrAck !== 1'b1) begin failures++; $display("[TB] FAIL ptr_wrap_addr_ack got=%b want=1", raddrAck); end
    for (int k = 0; k < 4; k++) begin
      exp = model_read();
      checks++; if (rbuf[k] !== exp) begin failures++; $display("[TB] FAIL ptr_wrap_byte%0d got=%h want=%h", k, rbuf[k], exp); end
    end
  endtask

  task automatic test_random();
    int n;
    logic [7:0] exp;
    for (int it = 0; it < 8; it++) begin
      n = 1 + $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
      expStb.delete(); gotStb.delete();
      write_txn(n, 1'b1, -1);
      model_write(n);
      for (int i = 0; i <= n; i++) begin
        checks++; if (wacks[i] !== 1'b1) begin failures++; $display("[TB] FAIL random%0d_ack%0d got=%b want=1", it, i, wacks[i]); end
      end
      checks++; if (gotStb.size() != expStb.size()) begin failures++; $display("[TB] FAIL random%0d_stb_count got=%0d want=%0d", it, gotStb.size(), expStb.size()); end
      for (int i = 0; i < expStb.size() && i < gotStb.size(); i++) begin
        checks++; if (gotStb[i] != expStb[i]) begin failures++; $display("[TB] FAIL random%0d_wr_idx%0d got=%0d want=%0d", it, i, gotStb[i], expStb[i]); end
      end
      checks++; if (REGS !== model_regs()) begin failures++; $display("[TB] FAIL random%0d_regs got=%h want=%h", it, REGS, model_regs()); end
      wbuf[0] = 8'($urandom_range(0, 255));
      write_txn(1, 1'b0, -1);
      model_write(1);
      n = $urandom_range(1, 5);
      read_txn(n);
      for (int k = 0; k < n; k++) begin
        exp = model_read();
        checks++; if (rbuf[k] !== exp) begin failures++; $display("[TB] FAIL random%0d_read%0d got=%h want=%h", it, k, rbuf[k], exp); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic a;
    logic [7:0] exp;
    wbuf[0] = 8'h00; wbuf[1] = 8'h00;
    write_txn(2, 1'b1, -1);
    model_write(2);
    wbuf[0] = 8'h00;
    write_txn(1, 1'b0, -1);
    model_write(1);
    i2c_start();
    send_byte(8'hFD, -1, a);
    m_sda = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(Q); m_scl = 1'b1; tick(H); m_scl = 1'b0; tick(Q);
    end
    tick(Q); m_scl = 1'b1; tick(H/2);
    checks++; if (SDA_OE !== 1'b1) begin failures++; $display("[TB] FAIL mid_read_driving got=%b want=1", SDA_OE); end
    RST_B = 1'b0;
    tick(1);
    checks++; if (SDA_OE !== 1'b0) begin failures++; $display("[TB] FAIL mid_read_release got=%b want=0", SDA_OE); end
    tick(2);
    RST_B = 1'b1;
    model_reset();
    checks++; if (REGS !== RESET_REGS) begin failures++; $display("[TB] FAIL mid_read_regs got=%h want=%h", REGS, RESET_REGS); end
    tick(H/2);
    m_scl = 1'b0; tick(Q);
    i2c_stop();
    tick(4);
    read_txn(3);
    checks++; if (raddrAck !== 1'b1) begin failures++; $display("[TB] FAIL after_reset_addr_ack got=%b want=1", raddrAck); end
    for (int k = 0; k < 3; k++) begin
      exp = model_read();
      checks++; if (rbuf[k] !== exp) begin failures++; $display("[TB] FAIL after_reset_byte%0d got=%h want=%h", k, rbuf[k], exp); end
    end
  endtask

`ifdef I2C_LD_TARGET_GLITCH_FILTER_EN
  task automatic test_glitch();
    wbuf[0] = 8'h03; wbuf[1] = 8'hA5; wbuf[2] = 8'h3C;
    expStb.delete(); gotStb.delete();
    write_txn(3, 1'b1, 1);
    model_write(3);
    for (int i = 0; i < 4; i++) begin
      checks++; if (wacks[i] !== 1'b1) begin failures++; $display("[TB] FAIL glitch_ack%0d got=%b want=1", i, wacks[i]); end
    end
    checks++; if (gotStb.size() != expStb.size()) begin failures++; $display("[TB] FAIL glitch_stb_count got=%0d want=%0d", gotStb.size(), expStb.size()); end
    checks++; if (REGS !== model_regs()) begin failures++; $display("[TB] FAIL glitch_regs got=%h want=%h", REGS, model_regs()); end
  endtask
`endif

  initial begin
    test_reset();
    test_default_read();
    test_write_all();
    test_bad_addr();
    test_ptr_wrap();
    test_random();
    test_reset_mid_read();
`ifdef I2C_LD_TARGET_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_ld_target.md
I2C_LD_TARGET -- requirements
Module: i2c_ld_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h7E, is the 7-bit target address (8'hFC write byte / 8'hFD read byte).
REQ-002 CLK40  input  1  sole clock; all logic is on its rising edge.
REQ-003 RST_B  input  1  reset, synchronous and active-low.
REQ-004 SCL_IN  input  1  I2C clock from the bus; asynchronous to CLK40.
REQ-005 SDA_IN  input  1  I2C data from the bus; asynchronous to CLK40.
REQ-006 SDA_OE  output  1  1 = pull SDA low; 0 = release; drives the external tristate.
REQ-007 REGS  output  56  register file, {reg6,...,reg0}, 8 bits each.
REQ-008 WR_STB  output  1  one-cycle pulse when any register byte is written.
REQ-009 WR_IDX  output  3  index of the register written; valid with WR_STB.
REQ-010 BUSY  output  1  high from an address-matched START until STOP or return to IDLE.

Function
REQ-011 SCL_IN and SDA_IN SHALL pass through 2-flop synchronizers; every edge and condition detection SHALL use the synchronized values.
REQ-012 START: sync SDA falls while sync SCL is high. STOP: sync SDA rises while sync SCL is high. Both are detected in every state.
REQ-013 Bits are sampled on the sync SCL rising edge; SDA_OE changes only on the sync SCL falling edge, MSB first.
REQ-014 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
  - START from any state -> ADDR with bit counter cleared; this covers repeated START.
  - STOP from any state -> IDLE with SDA_OE = 0.
REQ-015 ADDR: after 8 bits, if bits[7:1] == DEV_ADDR -> ADDR_ACK; otherwise -> IDLE with no ACK driven.
REQ-016 ACK states SHALL assert SDA_OE from the falling edge after bit 8 until the falling edge after bit 9.
REQ-017 After ADDR_ACK: R/W = 0 -> PTR; R/W = 1 -> RD_DATA.
REQ-018 PTR: byte[2:0] loads the 3-bit pointer; byte[7:3] is ignored; -> PTR_ACK -> WR_DATA.
REQ-019 WR_DATA: after 8 bits, the byte is written to reg[pointer] if pointer <= 6.
  - WR_STB pulses for one cycle and WR_IDX = pointer.
  - The pointer then increments modulo 8 -> WR_ACK -> WR_DATA.
REQ-020 Pointer 7 is unimplemented: writes are ACKed but not stored, with no WR_STB; reads return 8'h00.
REQ-021 RD_DATA: the shift byte loads reg[pointer] at the falling edge ending the preceding ACK; SDA_OE = ~bit, MSB first.
  - The pointer increments modulo 8 after the 8th bit -> RD_ACK.
REQ-022 RD_ACK: SDA_OE = 0.
  - Master ACK (SDA low at 9th rise) -> RD_DATA.
  - Master NACK -> IDLE; a following STOP is tolerated.
REQ-023 The pointer SHALL persist across transactions, so a write of a pointer alone followed by a repeated-START read reads from that pointer.
REQ-024 A write with a simultaneous START/STOP in the same cycle SHALL be discarded; START/STOP has priority over bit sampling.
REQ-025 BUSY = 1 in every state except IDLE and ADDR.

Reset
REQ-026 With RST_B low at a CLK40 edge:
  - FSM -> IDLE, pointer = 0, bit counter = 0.
  - SDA_OE = 0, WR_STB = 0, WR_IDX = 0, BUSY = 0.
  - Synchronizers are set to 1.
REQ-027 REGS reset to defaults {8'h04,8'hFF,8'hFF,8'h88,8'h00,8'h80,8'h87} (reg6..reg0).
REQ-028 Reset mid-transaction SHALL release SDA within one cycle; the bus transaction is abandoned until the next START.

Configuration
REQ-029 Macro I2C_LD_TARGET_GLITCH_FILTER_EN:
  - Defined: each synchronized line SHALL change only after 3 consecutive equal samples, adding 2 cycles of detection latency.
  - Undefined: the 2-flop synchronizer output is used directly.
  - Register behaviour is identical either way at SCL <= 1 MHz.

Verification
REQ-030 Reset, then read 7 bytes from pointer 0 -> 87,80,00,88,FF,FF,04; ACK after address; SDA released after master NACK.
REQ-031 Write FC,00,64,55,33,E7,1C,73,02 -> REGS = 56'h02731CE7335564; 7 WR_STB pulses with WR_IDX 0..6; every byte ACKed.
REQ-032 Write address 8'hF8 -> no ACK (SDA_OE stays 0), BUSY stays 0, REGS unchanged.
REQ-033 Write FC,05 then repeated START FD, read 4 bytes -> reg5, reg6, 00, reg0 (pointer wraps 7->0).
REQ-034 Assert RST_B low during bit 4 of a read byte -> SDA_OE = 0 next cycle, REGS at defaults; the next transaction completes normally.
REQ-035 With I2C_LD_TARGET_GLITCH_FILTER_EN defined, inject a 1-cycle SCL low glitch mid-byte -> no extra bit counted; the byte is stored correctly.
